vout_hbridge_deadtime: RTL
==========================

# vout_hbridge_deadtime

Full-bridge gate driver stage that sits directly downstream of the signed PWM generator. It consumes that generator's `pwm`/`dir` pair and produces four gate signals for a two-leg H-bridge. Each leg gets shoot-through protection via programmable dead time. An external over-current/fault input is synchronised and latched, and forces all gates off.

## Interface
- `DEADTIME`, default 50: both-switches-off interval per leg, in clk cycles.
  - Legal range 1..65535; 0 is an elaboration error.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pwm`  in  1  PWM from the upstream generator, same clock domain.
- `dir`  in  1  direction from the upstream generator (1 = forward); same domain.
- `enable`  in  1  bridge enable, same domain.
- `fault_in`  in  1  asynchronous external fault, active high.
- `hs_a`, `ls_a`  out  1 each  leg A high-side and low-side gates.
- `hs_b`, `ls_b`  out  1 each  leg B high-side and low-side gates.
- `fault_latched`  out  1  latched fault status.
- `active`  out  1  high while any gate is on.

## Operation
- Commanded leg state is derived each cycle from the inputs:
  - `dir`=1: leg A = HI when `pwm`=1, else LO; leg B = LO.
  - `dir`=0: leg B = HI when `pwm`=1, else LO; leg A = LO.
  - `enable`=0 or `fault_latched`=1: both legs = OFF.
- Each leg runs an independent FSM with states OFF, HI, LO, DEAD and a 16-bit dead counter.
  - HI drives hs=1, ls=0. LO drives hs=0, ls=1. OFF and DEAD drive both gates 0.
- FSM transitions:
  - OFF/HI/LO → OFF: immediate on the next edge.
  - HI→LO, LO→HI, OFF→HI, OFF→LO: always via DEAD; the counter loads DEADTIME-1.
  - DEAD: counter decrements each cycle. At 0, the FSM enters the commanded state sampled on that cycle.
    - If that command is OFF, it enters OFF.
    - If the command equals the pre-DEAD state, it still completes the full DEAD interval.
  - DEAD → OFF: immediate if the command becomes OFF.
- Consequence: command pulses shorter than DEADTIME are absorbed. No gate is ever on for less than one cycle, and hs/ls of a leg are never simultaneously 1.
- Direction change: the leg leaving LO (it was the held-low leg) goes through DEAD before switching to HI. The other leg goes HI/LO→DEAD→LO. Both legs obey dead time independently.
- Fault path:
  - `fault_in` passes through a 2-flop synchroniser; synchronised high sets `fault_latched`.
  - `fault_latched` clears only on a cycle where `enable`=0 and the synchronised fault is 0.
  - While latched, the commanded state is OFF for both legs.
- `active` = OR of the four registered gate outputs, itself registered.

## Timing
- Reset value of every output is 0; the synchroniser flops are 0, FSMs are OFF, and counters are 0.
  - Reset asserted mid-operation forces all gates to 0 asynchronously.
- Gate outputs are registered. An input change at edge n changes the FSM state and gates at edge n+1.
- HI→LO: `hs` falls at n+1 and `ls` rises at n+1+DEADTIME. LO→HI is symmetric.
- Fault latency: `fault_in` rise → `fault_latched` high in 2–3 cycles (metastability window) → all gates 0 one cycle later. This is worst-case 4 cycles.
- `active` lags gates by one cycle.
- Simultaneous fault and transition: fault/OFF takes priority over any pending DEAD completion.

## Configuration
- `VOUT_HBRIDGE_BRAKE_EN`:
  - Defined:
    - `enable`=0 with no fault commands both legs to LO (low-side brake). Entry is via DEAD per the normal rules.
    - A fault still forces OFF.
  - Undefined: `enable`=0 commands OFF (coast). The brake path is not synthesised.

## Test plan
- Reset: assert `rst` with `enable`=1, `pwm`=1, `dir`=1 → all six outputs 0; after release, `ls_b`=1 at DEADTIME+1 cycles and `hs_a`=1 at DEADTIME+1 cycles.
- Dead time, DEADTIME=5, `dir`=1, `enable`=1: `pwm` 1→0 at steady HI → `hs_a`=0 next cycle, `ls_a`=1 exactly 5 cycles later, never both 1.
- Glitch absorption, DEADTIME=5: `pwm` low pulse of 2 cycles during HI → `hs_a` off for exactly 5 cycles, then back on, with `ls_a` staying 0.
- Direction reversal at `pwm`=1: `dir` 1→0 → `hs_a` off and `ls_b` off next cycle; `ls_a` and `hs_b` on 5 cycles later; shoot-through monitor clean throughout.
- Fault: pulse `fault_in` for 1 cycle mid-PWM → all gates 0 within 4 cycles and `fault_latched`=1 held; it clears only after `enable`=0 for one cycle.
- With `VOUT_HBRIDGE_BRAKE_EN`: drop `enable` during HI → `hs_a` off, and `ls_a`/`ls_b` on after DEADTIME; without the macro, all gates stay 0.

Source files
------------

// File: rtl/vout_hbridge_deadtime.sv
// vout_hbridge_deadtime
// H-bridge gate driver with per-leg dead time and a latched fault shutdown.
// Two leg FSMs (OFF/HI/LO/DEAD) turn the upstream pwm/dir pair into four gates.
// Optional feature macro: VOUT_HBRIDGE_BRAKE_EN. When it is defined, enable=0
// with no fault brakes both legs low-side; when undefined, enable=0 coasts
// with all gates off.

module vout_hbridge_leg #(
   parameter logic [15:0] DT_LOAD = 16'd49
) (
   input  logic clk,
   input  logic rst,
   input  logic cmd_off,
   input  logic cmd_hi,
   output logic hs,
   output logic ls
);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_HI   = 2'd1,
      ST_LO   = 2'd2,
      ST_DEAD = 2'd3
   } leg_state_t;

   leg_state_t  state_r;
   leg_state_t  state_s;
   leg_state_t  cmd_state_s;
   logic [15:0] cnt_r;
   logic [15:0] cnt_s;
   logic        hs_r;
   logic        ls_r;

   // Next-state logic: every switch-on or HI/LO swap goes through DEAD, OFF is immediate
   always_comb begin
      state_s     = state_r;
      cnt_s       = 16'd0;
      cmd_state_s = ST_OFF;
      if (cmd_off) begin
         cmd_state_s = ST_OFF;
      end else if (cmd_hi) begin
         cmd_state_s = ST_HI;
      end else begin
         cmd_state_s = ST_LO;
      end
      case (state_r)
         ST_OFF, ST_HI, ST_LO: begin
            if (cmd_state_s == ST_OFF) begin
               state_s = ST_OFF;
            end else if (cmd_state_s != state_r) begin
               state_s = ST_DEAD;
               cnt_s   = DT_LOAD;
            end else begin
               state_s = state_r;
            end
         end
         ST_DEAD: begin
            if (cmd_state_s == ST_OFF) begin
               state_s = ST_OFF;
            end else if (cnt_r == 16'd0) begin
               // The full interval always elapses, even if the command returned to the old state
               state_s = cmd_state_s;
            end else begin
               state_s = ST_DEAD;
               cnt_s   = cnt_r - 16'd1;
            end
         end
         default: begin
            state_s = ST_OFF;
            cnt_s   = 16'd0;
         end
      endcase
   end

   // State, dead counter and gate registers; gates decode the next state so they change with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_OFF;
         cnt_r   <= 16'd0;
         hs_r    <= 1'b0;
         ls_r    <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         hs_r    <= (state_s == ST_HI);
         ls_r    <= (state_s == ST_LO);
      end
   end

   assign hs = hs_r;
   assign ls = ls_r;

endmodule

module vout_hbridge_deadtime #(
   parameter int DEADTIME = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic pwm,
   input  logic dir,
   input  logic enable,
   input  logic fault_in,
   output logic hs_a,
   output logic ls_a,
   output logic hs_b,
   output logic ls_b,
   output logic fault_latched,
   output logic active
);

   if ((DEADTIME < 1) || (DEADTIME > 65535)) begin : g_bad_deadtime
      $error("vout_hbridge_deadtime: DEADTIME must be in 1..65535");
   end

   localparam logic [15:0] DT_LOAD = 16'(DEADTIME - 1);

   logic sync1_r;
   logic sync2_r;
   logic fault_latched_r;
   logic active_r;
   logic a_off_s;
   logic a_hi_s;
   logic b_off_s;
   logic b_hi_s;
   logic hs_a_s;
   logic ls_a_s;
   logic hs_b_s;
   logic ls_b_s;

   // Fault synchroniser and latch; the latch clears only while disabled with no fault present
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r         <= 1'b0;
         sync2_r         <= 1'b0;
         fault_latched_r <= 1'b0;
      end else begin
         sync1_r <= fault_in;
         sync2_r <= sync1_r;
         if (sync2_r) begin
            fault_latched_r <= 1'b1;
         end else if (!enable) begin
            fault_latched_r <= 1'b0;
         end else begin
            fault_latched_r <= fault_latched_r;
         end
      end
   end

   // Leg commands: fault forces OFF, disable coasts or brakes, otherwise dir picks the driven leg
   always_comb begin
      a_off_s = 1'b1;
      a_hi_s  = 1'b0;
      b_off_s = 1'b1;
      b_hi_s  = 1'b0;
      if (fault_latched_r) begin
         a_off_s = 1'b1;
         b_off_s = 1'b1;
      end else if (!enable) begin
`ifdef VOUT_HBRIDGE_BRAKE_EN
         a_off_s = 1'b0;
         b_off_s = 1'b0;
`else
         a_off_s = 1'b1;
         b_off_s = 1'b1;
`endif
      end else if (dir) begin
         a_off_s = 1'b0;
         a_hi_s  = pwm;
         b_off_s = 1'b0;
      end else begin
         a_off_s = 1'b0;
         b_off_s = 1'b0;
         b_hi_s  = pwm;
      end
   end

   vout_hbridge_leg #(.DT_LOAD(DT_LOAD)) u_leg_a (
      .clk     (clk),
      .rst     (rst),
      .cmd_off (a_off_s),
      .cmd_hi  (a_hi_s),
      .hs      (hs_a_s),
      .ls      (ls_a_s)
   );

   vout_hbridge_leg #(.DT_LOAD(DT_LOAD)) u_leg_b (
      .clk     (clk),
      .rst     (rst),
      .cmd_off (b_off_s),
      .cmd_hi  (b_hi_s),
      .hs      (hs_b_s),
      .ls      (ls_b_s)
   );

   // Activity flag follows the registered gates by one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_r <= 1'b0;
      end else begin
         active_r <= hs_a_s | ls_a_s | hs_b_s | ls_b_s;
      end
   end

   assign hs_a          = hs_a_s;
   assign ls_a          = ls_a_s;
   assign hs_b          = hs_b_s;
   assign ls_b          = ls_b_s;
   assign fault_latched = fault_latched_r;
   assign active        = active_r;

endmodule
